// File: rtl/pau_ctrl_pkg.sv
// Shared constants for the PA fault-control blocks: debounce defaults and fault polarity codes.
// No logic; sizing helpers only.
package pau_ctrl_pkg;

    localparam int IRQ_FILT_CYC_DEF = 16;
    localparam int IRQ_CNT_W_DEF    = 8;

    localparam logic FAULT_ACT_HIGH = 1'b1;
    localparam logic FAULT_ACT_LOW  = 1'b0;

    // Filter counter width: max(1, clog2(filt_cyc)) so FILT_CYC=1 still gets a legal 1-bit vector.
    function automatic int fc_width(input int filt_cyc);
        return (filt_cyc <= 2) ? 1 : $clog2(filt_cyc);
    endfunction

endpackage

// File: rtl/irq_debounce_glitch_filter.sv
// Glitch filter: lvl follows i only after FILT_CYC consecutive differing samples.
// Latency FILT_CYC clocks per transition, symmetric for both directions.
// No backpressure; samples i every clock.
module glitch_filter
    import pau_ctrl_pkg::*;
#(
    parameter int   FILT_CYC = IRQ_FILT_CYC_DEF,
    parameter logic RST_V    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i,
    output logic lvl
);

    localparam int             FC_W   = fc_width(FILT_CYC);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILT_CYC - 1);

    if (FILT_CYC < 1) begin : g_bad_filt
        $error("glitch_filter: FILT_CYC must be 1 or more");
    end

    logic [FC_W-1:0] fc;

    // Any sample matching lvl discards the partial run, so only an unbroken run can flip lvl.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= RST_V;
            fc  <= '0;
        end else if (i == lvl) begin
            fc  <= '0;
        end else if (fc == FC_MAX) begin
            lvl <= i;
            fc  <= '0;
        end else begin
            fc  <= fc + FC_W'(1);
        end
    end

endmodule

// File: rtl/irq_debounce.sv
// Fault-line debounce: filtered level, one-cycle rise pulse, sticky irq and saturating event count.
// Latency: lvl/rise FILT_CYC clocks after i settles; irq and cnt one clock after rise.
// No backpressure; irq holds until ack, a new event outranks a simultaneous ack.
module irq_debounce
    import pau_ctrl_pkg::*;
#(
    parameter int   FILT_CYC = IRQ_FILT_CYC_DEF,
    parameter logic ACT_LVL  = FAULT_ACT_HIGH,
    parameter logic RST_V    = 1'b0,
    parameter int   CNT_W    = IRQ_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             en,
    input  logic             ack,
    input  logic             cnt_clr,
    output logic             lvl,
    output logic             rise,
    output logic             irq,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic lvl_q;

    glitch_filter #(
        .FILT_CYC (FILT_CYC),
        .RST_V    (RST_V)
    ) u_filt (
        .clk (clk),
        .rst (rst),
        .i   (i),
        .lvl (lvl)
    );

    // rise decodes two flops, so it is high exactly for the first cycle of lvl==ACT_LVL
    // and carries no combinational path from the fault input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= RST_V;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign rise = (lvl == ACT_LVL) && (lvl_q != ACT_LVL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (rise && en) begin
            irq <= 1'b1;
        end else if (ack) begin
            irq <= 1'b0;
        end
    end

    // A clear coinciding with an event keeps that event, so the count restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr && rise) begin
            cnt <= CNT_W'(1);
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (rise && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_irq_debounce.sv
// Directed bench for irq_debounce with FILT_CYC=4, ACT_LVL=1, RST_V=0, CNT_W=4.
module tb_irq_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       i;
    logic       en;
    logic       ack;
    logic       cnt_clr;
    logic       lvl;
    logic       rise;
    logic       irq;
    logic [3:0] cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       i;
        logic       en;
        logic       ack;
        logic       clr;
        logic       lvl;
        logic       rise;
        logic       irq;
        logic [3:0] cnt;
        logic [1:0] fc;
    } vec_t;

    vec_t tbl[$];

    irq_debounce #(
        .FILT_CYC (4),
        .ACT_LVL  (1'b1),
        .RST_V    (1'b0),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .en      (en),
        .ack     (ack),
        .cnt_clr (cnt_clr),
        .lvl     (lvl),
        .rise    (rise),
        .irq     (irq),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_i(input logic v, input int n);
        i = v;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // inputs, then expected outputs after the next edge: i en ack clr | lvl rise irq cnt fc
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd0,2'd1}); // release with i already active
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd0,2'd2});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd0,2'd3});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,4'd0,2'd0});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,4'd1,2'd0});
        tbl.push_back('{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,4'd1,2'd0}); // ack clears irq
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,4'd1,2'd1}); // filtered deassert
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,4'd1,2'd2});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,4'd1,2'd3});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd0});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd1}); // 3-cycle glitch
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd2});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd3});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd0});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd0});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd1});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd2});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd1,2'd3});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,4'd1,2'd0});
        tbl.push_back('{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,4'd2,2'd0}); // ack during rise: set wins
        tbl.push_back('{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,4'd2,2'd0});
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,4'd2,2'd1}); // en=0 event
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,4'd2,2'd2});
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,4'd2,2'd3});
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd2,2'd0});
        tbl.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd2,2'd1});
        tbl.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd2,2'd2});
        tbl.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,4'd2,2'd3});
        tbl.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,4'd2,2'd0});
        tbl.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,4'd3,2'd0});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,4'd3,2'd0}); // late en does not set irq
        tbl.push_back('{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,4'd0,2'd0}); // plain cnt_clr

        rst = 1'b1; i = 1'b1; en = 1'b1; ack = 1'b0; cnt_clr = 1'b0;
        step();
        step();
        chk("rst_lvl",  int'(lvl),  0);
        chk("rst_rise", int'(rise), 0);
        chk("rst_irq",  int'(irq),  0);
        chk("rst_cnt",  int'(cnt),  0);
        chk("rst_fc",   int'(dut.u_filt.fc), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            i = tbl[r].i; en = tbl[r].en; ack = tbl[r].ack; cnt_clr = tbl[r].clr;
            step();
            chk($sformatf("row%0d_lvl", r),  int'(lvl),  int'(tbl[r].lvl));
            chk($sformatf("row%0d_rise", r), int'(rise), int'(tbl[r].rise));
            chk($sformatf("row%0d_irq", r),  int'(irq),  int'(tbl[r].irq));
            chk($sformatf("row%0d_cnt", r),  int'(cnt),  int'(tbl[r].cnt));
            chk($sformatf("row%0d_fc", r),   int'(dut.u_filt.fc), int'(tbl[r].fc));
        end
        ack = 1'b0; cnt_clr = 1'b0; en = 1'b1;

        // Saturation: 17 events from cnt=0, count must stop at 15.
        for (int k = 1; k <= 17; k++) begin
            hold_i(1'b0, 4);
            hold_i(1'b1, 4);
            chk($sformatf("sat%0d_rise", k), int'(rise), 1);
            step();
            chk($sformatf("sat%0d_cnt", k), int'(cnt), (k > 15) ? 15 : k);
            chk($sformatf("sat%0d_irq", k), int'(irq), 1);
        end
        en = 1'b0;
        hold_i(1'b1, 3);
        chk("sat_hold_cnt", int'(cnt), 15);
        chk("en_drop_keeps_irq", int'(irq), 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_clears_irq", int'(irq), 0);

        // cnt_clr coinciding with rise restarts at 1.
        hold_i(1'b0, 4);
        hold_i(1'b1, 4);
        chk("clr_rise_pulse", int'(rise), 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_rise_cnt", int'(cnt), 1);
        chk("clr_rise_irq_gated", int'(irq), 0);

        // Async reset mid-filter.
        hold_i(1'b0, 4);
        chk("pre_arst_lvl", int'(lvl), 0);
        hold_i(1'b1, 2);
        chk("pre_arst_fc", int'(dut.u_filt.fc), 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_lvl", int'(lvl), 0);
        chk("arst_fc",  int'(dut.u_filt.fc), 0);
        chk("arst_cnt", int'(cnt), 0);
        chk("arst_irq", int'(irq), 0);
        #1 rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk($sformatf("post_arst%0d_lvl", e),  int'(lvl),  (e == 4) ? 1 : 0);
            chk($sformatf("post_arst%0d_rise", e), int'(rise), (e == 4) ? 1 : 0);
            chk($sformatf("post_arst%0d_fc", e),   int'(dut.u_filt.fc), (e == 4) ? 0 : e);
        end
        step();
        chk("post_arst_cnt", int'(cnt), 1);
        chk("post_arst_irq", int'(irq), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
